decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the 5-stage MIPS-subset pipeline. Sits between instruction fetch and execute.
//  - Holds the 32x32 register file and decodes the IF/ID instruction.
//  - Resolves branches and jumps in ID, with one architectural delay slot and no flush.
//  - Drives the PC-redirect bus back to fetch and registers the ID/EX pipeline outputs.
// PARAMETERS
//  LINK_REG   31         destination register for the JAL link write
//  EPC_ADJUST 32'h4      subtracted from if_id_nextpc to form id_epc
// PORTS
//  clock             in  1   rising-edge clock
//  reset             in  1   synchronous, active-high reset
//  if_id_instruc     in  32  instruction in IF/ID; 32'h0 is NOP
//  if_id_nextpc      in  32  PC+4 of if_id_instruc
//  ex_if_stall       in  1   execute stall; ID/EX holds, redirects suppressed
//  wb_id_writereg    in  1   writeback register-file write enable
//  wb_id_regdest     in  5   writeback destination register
//  wb_id_writedata   in  32  writeback data
//  id_if_selpcsource out 1   redirect fetch PC this cycle (combinational)
//  id_if_selpctype   out 2   00 branch, 01 JR, 10 J/JAL, 11 exception vector 0x40
//  id_if_rega        out 32  regfile[rs], the JR target (combinational)
//  id_if_pcimd2ext   out 32  branch target (combinational)
//  id_if_pcindex     out 32  jump target (combinational)
//  id_ex_rega/regb   out 32  registered rs/rt operands
//  id_ex_imedext     out 32  registered sign-extended imm16
//  id_ex_nextpc      out 32  registered if_id_nextpc
//  id_ex_regdest     out 5   registered destination register (rd / rt / LINK_REG)
//  id_ex_aluop       out 3   0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 PASS_LINK
//  id_ex_writereg    out 1   registered register-write enable
//  id_ex_memread     out 1   registered load flag
//  id_ex_memwrite    out 1   registered store flag
//  id_exc            out 1   one-cycle illegal-instruction pulse (registered)
//  id_epc            out 32  address of the faulting instruction
// BEHAVIOUR
//  Reset:
//  - Every registered output is 0. All 32 registers are cleared.
//  - Reset has priority over writeback, stall and decode.
//  Decode set:
//  - R-type op 0x00, funct ADD 0x20 / SUB 0x22 / AND 0x24 / OR 0x25 / SLT 0x2A / JR 0x08.
//  - I-type: ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05.
//  - J-type: J 0x02, JAL 0x03.
//  - An all-zero word is NOP. Any other encoding is illegal.
//  Register file:
//  - r0 always reads 0; writes to r0 are ignored.
//  - Write happens at the clock edge when wb_id_writereg=1.
//  Target arithmetic (32-bit, wraps modulo 2^32):
//  - pcimd2ext = nextpc + (sext(imm16)<<2).
//  - pcindex = {nextpc[31:28], instr[25:0], 2'b00}.
//  Redirect, only while ex_if_stall=0:
//  - BEQ taken when rs==rt; BNE taken when rs!=rt; type 00.
//  - JR: type 01. J and JAL: type 10. Illegal: type 11.
//  - selpcsource is high only while the redirecting instruction occupies IF/ID.
//  - The delay-slot instruction always executes.
//  ID/EX register update:
//  - ex_if_stall=1: all ID/EX outputs hold.
//  - ex_if_stall=0: load the decode of if_id_instruc.
//  - Illegal instruction, branch, J, JR and NOP load a bubble: writereg, memread and memwrite = 0.
//  - JAL: regdest=LINK_REG, aluop=PASS_LINK, writereg=1. Execute forms link = nextpc+4.
//  - LW/ADDI: regdest=rt. R-type: regdest=rd. SW: memwrite=1, writereg=0.
//  Exception:
//  - Illegal instruction with ex_if_stall=0: id_exc=1 for the next cycle only.
//  - id_epc <= if_id_nextpc - EPC_ADJUST; it holds until the next exception.
//  - Illegal instruction under stall: no pulse; re-evaluated when the stall drops.
//  Same-cycle writeback to a register being read:
//  - The read returns the old value unless the bypass below is compiled in.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//  - A read whose index equals wb_id_regdest with wb_id_writereg=1 returns wb_id_writedata.
//  - Applies to both the redirect compare and the ID/EX operands; r0 is excluded.
//  REGFILE_BYPASS_EN undefined:
//  - The read returns the stored value; writeback must precede the reader by one cycle.
// TESTING
//  - Reset held 1 cycle mid-stream -> all id_ex_* = 0, id_exc=0; r5 reads 0 afterwards.
//  - WB r1=5, r2=5; BEQ r1,r2,+3 at nextpc 0x104 -> selpcsource=1, type 00, pcimd2ext=0x110.
//  - JAL 0x0000100, nextpc 0x2004 -> type 10, pcindex=0x400; next edge regdest=31, aluop=5, writereg=1.
//  - ex_if_stall=1 with JR r3 in IF/ID -> selpcsource=0, ID/EX holds; stall low -> type 01, rega=r3.
//  - Opcode 0x3F at nextpc 0x84 -> type 11; id_exc pulses 1 cycle, id_epc=0x80, ID/EX bubble.
//  - WB r4=0xDEAD same cycle as ADD r6,r4,r0 -> id_ex_rega=0xDEAD with bypass, old r4 without.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : ID stage of a 5-stage MIPS-subset pipeline.
//               - Holds the 32x32 register file and decodes the IF/ID word.
//               - Resolves BEQ/BNE/J/JAL/JR in ID. There is one architectural
//                 delay slot and no flush.
//               - Drives the PC-redirect bus back to fetch.
//               - Registers the ID/EX pipeline outputs.
// Config      : `REGFILE_BYPASS_EN -- when defined, a read of the register
//               being written back in the same cycle returns the writeback
//               data (r0 excluded). When undefined, the read returns the
//               stored value.
// Ports       : clock, reset (sync, active-high)
//               if_id_instruc/if_id_nextpc     instruction and its PC+4
//               ex_if_stall                    hold ID/EX, suppress redirect
//               wb_id_writereg/regdest/writedata  register-file write port
//               id_if_*                        redirect bus to fetch (comb)
//               id_ex_*                        registered ID/EX outputs
//               id_exc/id_epc                  illegal-instruction report
// Revision    : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int unsigned LINK_REG   = 31,
    parameter logic [31:0] EPC_ADJUST = 32'h4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_id_instruc,
    input  logic [31:0] if_id_nextpc,
    input  logic        ex_if_stall,
    input  logic        wb_id_writereg,
    input  logic [4:0]  wb_id_regdest,
    input  logic [31:0] wb_id_writedata,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_pcindex,
    output logic [31:0] id_ex_rega,
    output logic [31:0] id_ex_regb,
    output logic [31:0] id_ex_imedext,
    output logic [31:0] id_ex_nextpc,
    output logic [4:0]  id_ex_regdest,
    output logic [2:0]  id_ex_aluop,
    output logic        id_ex_writereg,
    output logic        id_ex_memread,
    output logic        id_ex_memwrite,
    output logic        id_exc,
    output logic [31:0] id_epc
);

    // Opcodes
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    // R-type function codes
    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_or    = 6'h25;
    localparam logic [5:0] c_fn_slt   = 6'h2A;
    // ALU operations
    localparam logic [2:0] c_alu_add  = 3'd0;
    localparam logic [2:0] c_alu_sub  = 3'd1;
    localparam logic [2:0] c_alu_and  = 3'd2;
    localparam logic [2:0] c_alu_or   = 3'd3;
    localparam logic [2:0] c_alu_slt  = 3'd4;
    localparam logic [2:0] c_alu_link = 3'd5;
    // Redirect types
    localparam logic [1:0] c_pc_branch = 2'b00;
    localparam logic [1:0] c_pc_jr     = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;
    localparam logic [1:0] c_pc_exc    = 2'b11;
    localparam logic [4:0] c_link_reg  = 5'(LINK_REG);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] regfile_q [32];
    logic [31:0] rega_q, regb_q, imedext_q, nextpc_q, epc_q;
    logic [4:0]  regdest_q;
    logic [2:0]  aluop_q;
    logic        writereg_q, memread_q, memwrite_q, exc_q;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm_sext;

    assign w_opcode   = if_id_instruc[31:26];
    assign w_rs       = if_id_instruc[25:21];
    assign w_rt       = if_id_instruc[20:16];
    assign w_rd       = if_id_instruc[15:11];
    assign w_funct    = if_id_instruc[5:0];
    assign w_imm_sext = {{16{if_id_instruc[15]}}, if_id_instruc[15:0]};

    // ------------------------------------------------------------------
    // Register-file read ports (r0 hardwired to zero)
    // ------------------------------------------------------------------
    logic [31:0] w_rs_val, w_rt_val;

    always_comb begin
        w_rs_val = (w_rs == 5'd0) ? 32'd0 : regfile_q[w_rs];
        w_rt_val = (w_rt == 5'd0) ? 32'd0 : regfile_q[w_rt];
`ifdef REGFILE_BYPASS_EN
        // Forward the writeback value so a same-cycle reader sees new data
        if (wb_id_writereg && (wb_id_regdest == w_rs) && (w_rs != 5'd0))
            w_rs_val = wb_id_writedata;
        if (wb_id_writereg && (wb_id_regdest == w_rt) && (w_rt != 5'd0))
            w_rt_val = wb_id_writedata;
`endif
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_illegal, w_take;
    logic [1:0] w_pctype;
    logic [4:0] w_regdest;
    logic [2:0] w_aluop;
    logic       w_writereg, w_memread, w_memwrite;

    // Bubbles (NOP, branches, J, JR, illegal) leave every control field 0.
    always_comb begin
        w_illegal  = 1'b0;
        w_take     = 1'b0;
        w_pctype   = c_pc_branch;
        w_regdest  = 5'd0;
        w_aluop    = c_alu_add;
        w_writereg = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        case (w_opcode)
            c_op_rtype: begin
                if (if_id_instruc != 32'd0) begin
                    case (w_funct)
                        c_fn_add: begin w_regdest = w_rd; w_aluop = c_alu_add; w_writereg = 1'b1; end
                        c_fn_sub: begin w_regdest = w_rd; w_aluop = c_alu_sub; w_writereg = 1'b1; end
                        c_fn_and: begin w_regdest = w_rd; w_aluop = c_alu_and; w_writereg = 1'b1; end
                        c_fn_or:  begin w_regdest = w_rd; w_aluop = c_alu_or;  w_writereg = 1'b1; end
                        c_fn_slt: begin w_regdest = w_rd; w_aluop = c_alu_slt; w_writereg = 1'b1; end
                        c_fn_jr:  begin w_take = 1'b1; w_pctype = c_pc_jr; end
                        default:  w_illegal = 1'b1;
                    endcase
                end
            end
            c_op_addi: begin
                w_regdest  = w_rt;
                w_writereg = 1'b1;
            end
            c_op_lw: begin
                w_regdest  = w_rt;
                w_writereg = 1'b1;
                w_memread  = 1'b1;
            end
            c_op_sw: begin
                w_regdest  = w_rt;
                w_memwrite = 1'b1;
            end
            c_op_beq: w_take = (w_rs_val == w_rt_val);
            c_op_bne: w_take = (w_rs_val != w_rt_val);
            c_op_j: begin
                w_take   = 1'b1;
                w_pctype = c_pc_jump;
            end
            c_op_jal: begin
                w_take     = 1'b1;
                w_pctype   = c_pc_jump;
                w_regdest  = c_link_reg;
                w_aluop    = c_alu_link;
                w_writereg = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_take   = 1'b1;
            w_pctype = c_pc_exc;
        end
    end

    // ------------------------------------------------------------------
    // Redirect bus (combinational)
    // ------------------------------------------------------------------
    assign id_if_selpcsource = w_take & ~ex_if_stall;
    assign id_if_selpctype   = w_pctype;
    assign id_if_rega        = w_rs_val;
    assign id_if_pcimd2ext   = if_id_nextpc + {w_imm_sext[29:0], 2'b00};
    assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

    // ------------------------------------------------------------------
    // Register file write, ID/EX register, exception report
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regfile_q[i] <= 32'd0;
            rega_q     <= 32'd0;
            regb_q     <= 32'd0;
            imedext_q  <= 32'd0;
            nextpc_q   <= 32'd0;
            regdest_q  <= 5'd0;
            aluop_q    <= 3'd0;
            writereg_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            exc_q      <= 1'b0;
            epc_q      <= 32'd0;
        end else begin
            if (wb_id_writereg && (wb_id_regdest != 5'd0))
                regfile_q[wb_id_regdest] <= wb_id_writedata;

            if (!ex_if_stall) begin
                rega_q     <= w_rs_val;
                regb_q     <= w_rt_val;
                imedext_q  <= w_imm_sext;
                nextpc_q   <= if_id_nextpc;
                regdest_q  <= w_regdest;
                aluop_q    <= w_aluop;
                writereg_q <= w_writereg;
                memread_q  <= w_memread;
                memwrite_q <= w_memwrite;
                exc_q      <= w_illegal;
                if (w_illegal)
                    epc_q <= if_id_nextpc - EPC_ADJUST;
            end else begin
                // A stalled illegal instruction is re-evaluated later, so no pulse now
                exc_q <= 1'b0;
            end
        end
    end

    assign id_ex_rega     = rega_q;
    assign id_ex_regb     = regb_q;
    assign id_ex_imedext  = imedext_q;
    assign id_ex_nextpc   = nextpc_q;
    assign id_ex_regdest  = regdest_q;
    assign id_ex_aluop    = aluop_q;
    assign id_ex_writereg = writereg_q;
    assign id_ex_memread  = memread_q;
    assign id_ex_memwrite = memwrite_q;
    assign id_exc         = exc_q;
    assign id_epc         = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Directed scenarios plus
//               a randomized run compared against an instruction-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr, nextpc;
    logic        stall, wbw;
    logic [4:0]  wbr;
    logic [31:0] wbd;

    logic        o_src;
    logic [1:0]  o_type;
    logic [31:0] o_rega_if, o_pcimd, o_pcidx;
    logic [31:0] o_rega, o_regb, o_imm, o_npc, o_epc;
    logic [4:0]  o_dest;
    logic [2:0]  o_alu;
    logic        o_wr, o_mr, o_mw, o_exc;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset),
        .if_id_instruc(instr), .if_id_nextpc(nextpc), .ex_if_stall(stall),
        .wb_id_writereg(wbw), .wb_id_regdest(wbr), .wb_id_writedata(wbd),
        .id_if_selpcsource(o_src), .id_if_selpctype(o_type), .id_if_rega(o_rega_if),
        .id_if_pcimd2ext(o_pcimd), .id_if_pcindex(o_pcidx),
        .id_ex_rega(o_rega), .id_ex_regb(o_regb), .id_ex_imedext(o_imm),
        .id_ex_nextpc(o_npc), .id_ex_regdest(o_dest), .id_ex_aluop(o_alu),
        .id_ex_writereg(o_wr), .id_ex_memread(o_mr), .id_ex_memwrite(o_mw),
        .id_exc(o_exc), .id_epc(o_epc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    // expected combinational outputs for the current IF/ID word
    logic        x_src;
    logic [1:0]  x_type;
    logic [31:0] x_rega, x_pcimd, x_pcidx;
    // what the ID/EX register should capture at the next unstalled edge
    logic [31:0] n_rega, n_regb, n_imm, n_npc;
    logic [4:0]  n_dest;
    logic [2:0]  n_alu;
    logic        n_wr, n_mr, n_mw, n_chk, n_ill;
    // expected registered outputs
    logic [31:0] e_rega, e_regb, e_imm, e_npc, e_epc;
    logic [4:0]  e_dest;
    logic [2:0]  e_alu;
    logic        e_wr, e_mr, e_mw, e_chk, e_exc;

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wbw && wbr == idx) return wbd;
`endif
        return m_regs[idx];
    endfunction

    function automatic void model_eval();
        int op, fn;
        logic [4:0] rs, rt, rd;
        logic [31:0] a, b, off;
        op = int'(instr[31:26]);
        fn = int'(instr[5:0]);
        rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
        a = mread(rs); b = mread(rt);
        off = {16'd0, instr[15:0]};
        if (off >= 32'd32768) off = off - 32'd65536;
        x_pcimd = nextpc + off * 4;
        x_pcidx = (nextpc & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
        x_rega  = a;
        x_src = 0; x_type = 2'd0; n_ill = 0;
        n_dest = 0; n_alu = 0; n_wr = 0; n_mr = 0; n_mw = 0; n_chk = 0;
        if (instr == 32'd0) begin
            // NOP: bubble
        end else if (op == 0 && fn inside {32, 34, 36, 37, 42}) begin
            n_dest = rd; n_wr = 1; n_chk = 1;
            n_alu = (fn == 32) ? 3'd0 : (fn == 34) ? 3'd1 : (fn == 36) ? 3'd2 :
                    (fn == 37) ? 3'd3 : 3'd4;
        end else if (op == 0 && fn == 8) begin
            x_src = 1; x_type = 2'd1;
        end else if (op == 8 || op == 35) begin
            n_dest = rt; n_alu = 0; n_wr = 1; n_mr = (op == 35); n_chk = 1;
        end else if (op == 43) begin
            n_mw = 1;
        end else if (op == 4 || op == 5) begin
            x_src = ((op == 4) == (a == b));
        end else if (op == 2) begin
            x_src = 1; x_type = 2'd2;
        end else if (op == 3) begin
            x_src = 1; x_type = 2'd2; n_dest = 5'd31; n_alu = 3'd5; n_wr = 1; n_chk = 1;
        end else begin
            n_ill = 1; x_src = 1; x_type = 2'd3;
        end
        if (stall) x_src = 0;
        n_rega = a; n_regb = b; n_imm = off; n_npc = nextpc;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] npc, input logic stl,
                         input logic w, input logic [4:0] r, input logic [31:0] d);
        instr = ins; nextpc = npc; stall = stl; wbw = w; wbr = r; wbd = d;
        model_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            e_rega = 0; e_regb = 0; e_imm = 0; e_npc = 0; e_epc = 0;
            e_dest = 0; e_alu = 0; e_wr = 0; e_mr = 0; e_mw = 0; e_chk = 1; e_exc = 0;
        end else begin
            if (!stall) begin
                e_rega = n_rega; e_regb = n_regb; e_imm = n_imm; e_npc = n_npc;
                e_dest = n_dest; e_alu = n_alu; e_wr = n_wr; e_mr = n_mr; e_mw = n_mw;
                e_chk = n_chk; e_exc = n_ill;
                if (n_ill) e_epc = nextpc - 32'h4;
            end else begin
                e_exc = 0;
            end
            if (wbw && wbr != 5'd0) m_regs[wbr] = wbd;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        logic [31:0] rs, rt, rd, imm;
        k = $urandom_range(0, 15);
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        imm = $urandom_range(0, 65535);
        case (k)
            0:  return 32'd0;
            1:  return (rs << 21) | (rt << 16) | (rd << 11) | 32'h20;
            2:  return (rs << 21) | (rt << 16) | (rd << 11) | 32'h22;
            3:  return (rs << 21) | (rt << 16) | (rd << 11) | 32'h24;
            4:  return (rs << 21) | (rt << 16) | (rd << 11) | 32'h25;
            5:  return (rs << 21) | (rt << 16) | (rd << 11) | 32'h2A;
            6:  return (rs << 21) | 32'h08;
            7:  return (32'h08 << 26) | (rs << 21) | (rt << 16) | imm;
            8:  return (32'h23 << 26) | (rs << 21) | (rt << 16) | imm;
            9:  return (32'h2B << 26) | (rs << 21) | (rt << 16) | imm;
            10: return (32'h04 << 26) | (rs << 21) | (rt << 16) | imm;
            11: return (32'h05 << 26) | (rs << 21) | (rt << 16) | imm;
            12: return (32'h02 << 26) | ($urandom & 32'h03FF_FFFF);
            13: return (32'h03 << 26) | ($urandom & 32'h03FF_FFFF);
            14: return (32'h3F << 26) | ($urandom & 32'h03FF_FFFF);
            default: return (rs << 21) | (rt << 16) | (32'h1 << 11) | 32'h21;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        reset = 1'b0;
        n_tests++; if (o_wr !== 1'b0 || o_exc !== 1'b0) begin n_fail++; $display("FAIL reset_init wr/exc got %b/%b expected 0/0", o_wr, o_exc); end
        n_tests++; if (o_epc !== 32'd0) begin n_fail++; $display("FAIL reset_init_epc got %h expected 0", o_epc); end
        drive(32'd0, 32'h10, 1'b0, 1'b1, 5'd5, 32'h55); tick();
        drive(32'h20A7_1234, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        n_tests++; if (o_rega !== 32'h55 || o_wr !== 1'b1) begin n_fail++; $display("FAIL pre_reset_addi rega/wr got %h/%b expected 55/1", o_rega, o_wr); end
        // reset must win over a concurrent writeback and decode
        reset = 1'b1;
        drive(32'h20A7_1234, 32'h24, 1'b0, 1'b1, 5'd5, 32'h99); tick();
        reset = 1'b0;
        n_tests++;
        if ({o_rega, o_regb, o_imm, o_npc} !== 128'd0 || {o_dest, o_alu, o_wr, o_mr, o_mw, o_exc} !== 12'd0) begin
            n_fail++; $display("FAIL reset_midstream got rega=%h regb=%h imm=%h npc=%h dest=%0d alu=%0d wr=%b mr=%b mw=%b exc=%b expected all 0",
                               o_rega, o_regb, o_imm, o_npc, o_dest, o_alu, o_wr, o_mr, o_mw, o_exc);
        end
        drive(32'h00A0_0008, 32'h30, 1'b0, 1'b0, 5'd0, 32'd0);
        n_tests++; if (o_rega_if !== 32'd0) begin n_fail++; $display("FAIL reset_r5_cleared got %h expected 0", o_rega_if); end
        tick();
    endtask

    task automatic test_branch();
        drive(32'd0, 32'h100, 1'b0, 1'b1, 5'd1, 32'd5); tick();
        drive(32'd0, 32'h100, 1'b0, 1'b1, 5'd2, 32'd5); tick();
        drive(32'h1022_0003, 32'h104, 1'b0, 1'b0, 5'd0, 32'd0);
        n_tests++; if (o_src !== 1'b1 || o_type !== 2'b00) begin n_fail++; $display("FAIL beq_taken src/type got %b/%b expected 1/00", o_src, o_type); end
        n_tests++; if (o_pcimd !== 32'h110) begin n_fail++; $display("FAIL beq_target got %h expected 00000110", o_pcimd); end
        tick();
        n_tests++; if (o_wr !== 1'b0 || o_mr !== 1'b0 || o_mw !== 1'b0) begin n_fail++; $display("FAIL beq_bubble got wr=%b mr=%b mw=%b expected 0", o_wr, o_mr, o_mw); end
        drive(32'h1422_0003, 32'h108, 1'b0, 1'b0, 5'd0, 32'd0);
        n_tests++; if (o_src !== 1'b0) begin n_fail++; $display("FAIL bne_not_taken src got %b expected 0", o_src); end
        tick();
        // negative offset wraps backwards
        drive(32'h1022_FFFE, 32'h200, 1'b0, 1'b0, 5'd0, 32'd0);
        n_tests++; if (o_pcimd !== 32'h1F8) begin n_fail++; $display("FAIL beq_neg_target got %h expected 000001f8", o_pcimd); end
        tick();
    endtask

    task automatic test_jal();
        drive(32'h0C00_0100, 32'h2004, 1'b0, 1'b0, 5'd0, 32'd0);
        n_tests++; if (o_src !== 1'b1 || o_type !== 2'b10) begin n_fail++; $display("FAIL jal_redirect src/type got %b/%b expected 1/10", o_src, o_type); end
        n_tests++; if (o_pcidx !== 32'h400) begin n_fail++; $display("FAIL jal_target got %h expected 00000400", o_pcidx); end
        tick();
        n_tests++; if (o_dest !== 5'd31 || o_alu !== 3'd5 || o_wr !== 1'b1) begin n_fail++; $display("FAIL jal_idex dest/alu/wr got %0d/%0d/%b expected 31/5/1", o_dest, o_alu, o_wr); end
        n_tests++; if (o_npc !== 32'h2004) begin n_fail++; $display("FAIL jal_nextpc got %h expected 00002004", o_npc); end
    endtask

    task automatic test_jr_stall();
        drive(32'd0, 32'h2FC, 1'b0, 1'b1, 5'd3, 32'h1234); tick();
        drive(32'h0063_4820, 32'h300, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        drive(32'h0060_0008, 32'h304, 1'b1, 1'b0, 5'd0, 32'd0);
        n_tests++; if (o_src !== 1'b0) begin n_fail++; $display("FAIL jr_stalled_src got %b expected 0", o_src); end
        tick();
        n_tests++; if (o_dest !== 5'd9 || o_wr !== 1'b1 || o_npc !== 32'h300 || o_rega !== 32'h1234) begin
            n_fail++; $display("FAIL stall_hold got dest=%0d wr=%b npc=%h rega=%h expected 9/1/00000300/00001234", o_dest, o_wr, o_npc, o_rega);
        end
        drive(32'h0060_0008, 32'h304, 1'b0, 1'b0, 5'd0, 32'd0);
        n_tests++; if (o_src !== 1'b1 || o_type !== 2'b01 || o_rega_if !== 32'h1234) begin
            n_fail++; $display("FAIL jr_release got src=%b type=%b rega=%h expected 1/01/00001234", o_src, o_type, o_rega_if);
        end
        tick();
        n_tests++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL jr_bubble wr got %b expected 0", o_wr); end
    endtask

    task automatic test_illegal();
        drive(32'hFC00_0000, 32'h84, 1'b0, 1'b0, 5'd0, 32'd0);
        n_tests++; if (o_src !== 1'b1 || o_type !== 2'b11) begin n_fail++; $display("FAIL illegal_redirect src/type got %b/%b expected 1/11", o_src, o_type); end
        tick();
        n_tests++; if (o_exc !== 1'b1 || o_epc !== 32'h80) begin n_fail++; $display("FAIL illegal_exc got exc=%b epc=%h expected 1/00000080", o_exc, o_epc); end
        n_tests++; if (o_wr !== 1'b0 || o_mr !== 1'b0 || o_mw !== 1'b0) begin n_fail++; $display("FAIL illegal_bubble got wr=%b mr=%b mw=%b expected 0", o_wr, o_mr, o_mw); end
        drive(32'd0, 32'h88, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        n_tests++; if (o_exc !== 1'b0 || o_epc !== 32'h80) begin n_fail++; $display("FAIL illegal_pulse_end got exc=%b epc=%h expected 0/00000080", o_exc, o_epc); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_a;
`ifdef REGFILE_BYPASS_EN
        exp_a = 32'hDEAD;
`else
        exp_a = 32'h1111;
`endif
        drive(32'd0, 32'h3FC, 1'b0, 1'b1, 5'd4, 32'h1111); tick();
        drive(32'h0080_3020, 32'h400, 1'b0, 1'b1, 5'd4, 32'hDEAD); tick();
        n_tests++; if (o_rega !== exp_a) begin n_fail++; $display("FAIL same_cycle_wb rega got %h expected %h", o_rega, exp_a); end
        drive(32'h0080_3020, 32'h404, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        n_tests++; if (o_rega !== 32'hDEAD) begin n_fail++; $display("FAIL wb_next_cycle rega got %h expected 0000dead", o_rega); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            drive(rand_instr(), $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
            n_tests++;
            if (o_src !== x_src || o_rega_if !== x_rega || o_pcimd !== x_pcimd || o_pcidx !== x_pcidx ||
                (x_src && o_type !== x_type)) begin
                n_fail++; $display("FAIL rand_comb it=%0d instr=%h got src=%b type=%b rega=%h imd=%h idx=%h expected %b/%b/%h/%h/%h",
                                   it, instr, o_src, o_type, o_rega_if, o_pcimd, o_pcidx, x_src, x_type, x_rega, x_pcimd, x_pcidx);
            end
            tick();
            n_tests++;
            if (o_rega !== e_rega || o_regb !== e_regb || o_imm !== e_imm || o_npc !== e_npc ||
                o_wr !== e_wr || o_mr !== e_mr || o_mw !== e_mw || o_exc !== e_exc || o_epc !== e_epc ||
                (e_chk && (o_dest !== e_dest || o_alu !== e_alu))) begin
                n_fail++; $display("FAIL rand_idex it=%0d got a=%h b=%h i=%h pc=%h d=%0d op=%0d w=%b r=%b s=%b x=%b e=%h expected a=%h b=%h i=%h pc=%h d=%0d op=%0d w=%b r=%b s=%b x=%b e=%h",
                                   it, o_rega, o_regb, o_imm, o_npc, o_dest, o_alu, o_wr, o_mr, o_mw, o_exc, o_epc,
                                   e_rega, e_regb, e_imm, e_npc, e_dest, e_alu, e_wr, e_mr, e_mw, e_exc, e_epc);
            end
        end
    endtask

    initial begin
        reset = 1'b1; instr = 0; nextpc = 0; stall = 0; wbw = 0; wbr = 0; wbd = 0;
        @(posedge clock); #1;
        test_reset();
        test_branch();
        test_jal();
        test_jr_stall();
        test_illegal();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
